// File: rtl/prll_bs_pkg.sv
// Shared constants and helpers for the parallel-bus driver agent.
package prll_bs_pkg;

    localparam int ID_BITS  = 8;
    localparam int MAX_BITS = 64;
    localparam logic [ID_BITS-1:0] BROADCAST = {ID_BITS{1'b1}};

    // Destination field lives in the top fld_bits of a pkt_bits-wide packet.
    function automatic logic [MAX_BITS-1:0] dest_of(input logic [MAX_BITS-1:0] pkt,
                                                    input int pkt_bits,
                                                    input int fld_bits);
        logic [MAX_BITS-1:0] mask;
        mask = (MAX_BITS'(1) << fld_bits) - MAX_BITS'(1);
        return (pkt >> (pkt_bits - fld_bits)) & mask;
    endfunction

endpackage

// File: rtl/prll_bs_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a write while full is accepted
// when a read retires the head in the same cycle.
module prll_bs_sync_fifo
    import prll_bs_pkg::*;
#(
    parameter int bits  = 32,
    parameter int depth = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [bits-1:0]            din,
    output logic [bits-1:0]            dout,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(depth);
    localparam int CW = $clog2(depth+1);

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [bits-1:0] mem_q [depth];
    logic            wr_en, rd_en;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(depth));
    assign count = cnt_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    assign rd_en = rd && !empty;
    assign wr_en = wr && (!full || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: dout is masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/prll_bs_drvr_agent.sv
// Driver-side endpoint of the parallel-bus arbiter: TX FIFO toward the
// arbiter, destination-filtered RX FIFO from it, and sticky host status.
module prll_bs_drvr_agent
    import prll_bs_pkg::*;
#(
    parameter int                 bits      = 32,
    parameter int                 id_bits   = ID_BITS,
    parameter logic [id_bits-1:0] drvr_id   = '0,
    parameter logic [id_bits-1:0] broadcast = id_bits'(BROADCAST),
    parameter int                 depth     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tx_wr,
    input  logic [bits-1:0]            tx_data,
    output logic                       tx_full,
    output logic                       pndng,
    input  logic                       pop,
    output logic [bits-1:0]            D_pop,
    input  logic                       push,
    input  logic [bits-1:0]            D_push,
    input  logic                       rx_rd,
    output logic [bits-1:0]            rx_data,
    output logic                       rx_empty,
    output logic [$clog2(depth+1)-1:0] rx_count,
    input  logic                       sts_clr,
    output logic                       tx_ovf,
    output logic                       rx_ovf,
    output logic [7:0]                 rx_misroute
);

    localparam int CW = $clog2(depth+1);

    logic [CW-1:0]      tx_count;
    logic               tx_empty;
    logic               rx_full;
    logic [id_bits-1:0] dest;
    logic               dest_hit;
    logic               rx_wr;
    logic               tx_drop, rx_drop, mis_evt;
    logic               unused_tx_count;

    logic       tx_ovf_q, tx_ovf_d;
    logic       rx_ovf_q, rx_ovf_d;
    logic [7:0] mis_q, mis_d;

    prll_bs_sync_fifo #(.bits(bits), .depth(depth)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_wr),
        .rd    (pop),
        .din   (tx_data),
        .dout  (D_pop),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    prll_bs_sync_fifo #(.bits(bits), .depth(depth)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (rx_wr),
        .rd    (rx_rd),
        .din   (D_push),
        .dout  (rx_data),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign unused_tx_count = &{1'b0, tx_count};
    assign pndng           = !tx_empty;

    assign dest     = id_bits'(dest_of(MAX_BITS'(D_push), bits, id_bits));
    assign dest_hit = (dest == drvr_id) || (dest == broadcast);
    assign rx_wr    = push && dest_hit;

    // A full FIFO still takes the word when the same cycle frees a slot.
    assign tx_drop = tx_wr && tx_full && !pop;
    assign rx_drop = rx_wr && rx_full && !rx_rd;
    assign mis_evt = push && !dest_hit;

    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_ovf_d = rx_ovf_q;
        mis_d    = mis_q;
        if (sts_clr) begin
            tx_ovf_d = 1'b0;
            rx_ovf_d = 1'b0;
            mis_d    = '0;
        end
        // Errors take precedence over a coincident clear.
        if (tx_drop) tx_ovf_d = 1'b1;
        if (rx_drop) rx_ovf_d = 1'b1;
        if (mis_evt) begin
            if (sts_clr)               mis_d = 8'd1;
            else if (mis_q != 8'hFF)   mis_d = mis_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
            mis_q    <= '0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_ovf_q <= rx_ovf_d;
            mis_q    <= mis_d;
        end
    end

    assign tx_ovf      = tx_ovf_q;
    assign rx_ovf      = rx_ovf_q;
    assign rx_misroute = mis_q;

endmodule

// File: tb/tb_prll_bs_drvr_agent.sv
// Scoreboard bench: a queue-based model predicts every cycle's outputs,
// and an independent monitor compares them against the DUT.
module tb_prll_bs_drvr_agent;

    localparam int         DEPTH = 16;
    localparam logic [7:0] MY_ID = 8'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_wr = 1'b0, pop = 1'b0, push = 1'b0, rx_rd = 1'b0, sts_clr = 1'b0;
    logic [31:0] tx_data = '0, D_push = '0;
    logic        tx_full, pndng, rx_empty, tx_ovf, rx_ovf;
    logic [31:0] D_pop, rx_data;
    logic [4:0]  rx_count;
    logic [7:0]  rx_misroute;

    prll_bs_drvr_agent #(.bits(32), .id_bits(8), .drvr_id(MY_ID), .broadcast(8'hFF), .depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
        .pndng(pndng), .pop(pop), .D_pop(D_pop), .push(push), .D_push(D_push),
        .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .rx_count(rx_count),
        .sts_clr(sts_clr), .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .rx_misroute(rx_misroute)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        pndng;
        logic [31:0] d_pop;
        logic        tx_full;
        logic        rx_empty;
        logic [31:0] rx_data;
        logic [4:0]  rx_count;
        logic        tx_ovf;
        logic        rx_ovf;
        logic [7:0]  mis;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_tx[$];
    logic [31:0] m_rx[$];
    bit          m_txo, m_rxo;
    int          m_mis;
    int          checks = 0, errors = 0;
    event        async_ev;

    function automatic exp_t snap(input string tag);
        exp_t e;
        e.tag      = tag;
        e.pndng    = (m_tx.size() != 0);
        e.d_pop    = (m_tx.size() != 0) ? m_tx[0] : 32'h0;
        e.tx_full  = (m_tx.size() == DEPTH);
        e.rx_empty = (m_rx.size() == 0);
        e.rx_data  = (m_rx.size() != 0) ? m_rx[0] : 32'h0;
        e.rx_count = 5'(m_rx.size());
        e.tx_ovf   = m_txo;
        e.rx_ovf   = m_rxo;
        e.mis      = 8'(m_mis);
        return e;
    endfunction

    function automatic void model_clear();
        m_tx.delete();
        m_rx.delete();
        m_txo = 0;
        m_rxo = 0;
        m_mis = 0;
    endfunction

    // One clock of stimulus: drive, advance the model, queue the expectation.
    task automatic cyc(input logic w, input logic [31:0] wd, input logic p,
                       input logic ps, input logic [31:0] pd, input logic r,
                       input logic c, input string tag);
        bit tx_err, rx_err, mis_err, hit;
        @(negedge clk);
        tx_wr = w; tx_data = wd; pop = p; push = ps; D_push = pd; rx_rd = r; sts_clr = c;
        tx_err = w && (m_tx.size() == DEPTH) && !p;
        if (p && m_tx.size() != 0) void'(m_tx.pop_front());
        if (w && m_tx.size() < DEPTH) m_tx.push_back(wd);
        hit = (pd[31:24] == MY_ID) || (pd[31:24] == 8'hFF);
        rx_err  = ps && hit && (m_rx.size() == DEPTH) && !r;
        mis_err = ps && !hit;
        if (r && m_rx.size() != 0) void'(m_rx.pop_front());
        if (ps && hit && m_rx.size() < DEPTH) m_rx.push_back(pd);
        if (c) begin m_txo = 0; m_rxo = 0; m_mis = 0; end
        if (tx_err) m_txo = 1;
        if (rx_err) m_rxo = 1;
        if (mis_err && m_mis < 255) m_mis++;
        exp_q.push_back(snap(tag));
    endtask

    task automatic idle(input string tag);
        cyc(0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        tx_wr = 0; pop = 0; push = 0; rx_rd = 0; sts_clr = 0;
        model_clear();
        exp_q.push_back(snap("reset"));
        -> async_ev;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or async_ev);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(e.tag, "pndng",       32'(pndng),       32'(e.pndng));
                chk(e.tag, "D_pop",       D_pop,            e.d_pop);
                chk(e.tag, "tx_full",     32'(tx_full),     32'(e.tx_full));
                chk(e.tag, "rx_empty",    32'(rx_empty),    32'(e.rx_empty));
                chk(e.tag, "rx_data",     rx_data,          e.rx_data);
                chk(e.tag, "rx_count",    32'(rx_count),    32'(e.rx_count));
                chk(e.tag, "tx_ovf",      32'(tx_ovf),      32'(e.tx_ovf));
                chk(e.tag, "rx_ovf",      32'(rx_ovf),      32'(e.rx_ovf));
                chk(e.tag, "rx_misroute", 32'(rx_misroute), 32'(e.mis));
            end
        end
    end

    function automatic logic [31:0] rx_pkt();
        logic [7:0] d;
        d = ($urandom_range(0, 1) == 0) ? MY_ID : 8'hFF;
        return {d, 24'($urandom)};
    endfunction

    initial begin : driver
        logic [31:0] pd;
        model_clear();
        do_reset();

        // Basic TX path
        cyc(1, 32'h11, 0, 0, 0, 0, 0, "tx_w1");
        cyc(1, 32'h22, 0, 0, 0, 0, 0, "tx_w2");
        cyc(1, 32'h33, 0, 0, 0, 0, 0, "tx_w3");
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0, 0, "tx_pop");
        cyc(0, 0, 1, 0, 0, 0, 0, "tx_pop_empty");
        cyc(1, 32'h44, 1, 0, 0, 0, 0, "tx_wr_pop_empty");
        cyc(0, 0, 1, 0, 0, 0, 0, "tx_pop4");

        // TX full boundary
        for (int i = 0; i < DEPTH; i++) cyc(1, $urandom, 0, 0, 0, 0, 0, "tx_fill");
        cyc(1, 32'hDEAD0017, 0, 0, 0, 0, 0, "tx_drop");
        idle("tx_hold");
        cyc(1, 32'hBEEF0017, 1, 0, 0, 0, 0, "tx_full_wr_pop");
        cyc(0, 0, 0, 0, 0, 0, 1, "tx_clr");
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 1, 0, 0, 0, 0, "tx_drain");

        // RX filter
        cyc(0, 0, 0, 1, 32'h03ABCDEF, 0, 0, "rx_own");
        cyc(0, 0, 0, 1, 32'hFF000001, 0, 0, "rx_bcast");
        cyc(0, 0, 0, 1, 32'h05000000, 0, 0, "rx_foreign");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0, "rx_read");
        cyc(0, 0, 0, 0, 0, 0, 1, "rx_clr_mis");

        // RX full boundary and clear precedence
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 1, rx_pkt(), 0, 0, "rx_fill");
        cyc(0, 0, 0, 1, rx_pkt(), 0, 0, "rx_drop");
        cyc(0, 0, 0, 0, 0, 0, 1, "rx_clr");
        cyc(0, 0, 0, 1, rx_pkt(), 0, 1, "rx_clr_vs_drop");
        cyc(0, 0, 0, 1, rx_pkt(), 1, 0, "rx_full_push_rd");
        cyc(0, 0, 0, 1, 32'h77000000, 0, 1, "mis_clr_vs_err");
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 0, 0, 0, 1, 0, "rx_drain");

        // Misroute saturation
        for (int i = 0; i < 258; i++) cyc(0, 0, 0, 1, {8'h10, 24'($urandom)}, 0, 0, "mis_sat");
        cyc(0, 0, 0, 0, 0, 0, 1, "mis_clr");

        // Reset mid-stream
        for (int i = 0; i < 5; i++) cyc(1, $urandom, 0, 0, 0, 0, 0, "pre_rst_tx");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, rx_pkt(), 0, 0, "pre_rst_rx");
        do_reset();
        cyc(0, 0, 1, 0, 0, 1, 0, "post_rst_pop_rd");
        cyc(1, 32'hA5A5A5A5, 0, 1, rx_pkt(), 0, 0, "post_rst_new");
        cyc(0, 0, 1, 0, 0, 1, 0, "post_rst_drain");

        // Wrap-around with random gaps
        for (int i = 0; i < 40; i++)
            cyc(1'($urandom_range(0, 9) < 6), $urandom, 1'($urandom_range(0, 9) < 5),
                0, 0, 0, 0, "tx_wrap");

        // Fully random traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 2))
                0:       pd = {MY_ID, 24'($urandom)};
                1:       pd = {8'hFF, 24'($urandom)};
                default: pd = $urandom;
            endcase
            cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), pd, 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 19) == 0), "random");
        end

        idle("final");
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prll_bs_drvr_agent.md
# prll_bs_drvr_agent

Driver-side endpoint of the parallel-bus generator/arbiter: one instance per driver per bus. It sits on the opposite end of the arbiter's `pndng`/`pop`/`D_pop` and `push`/`D_push` signals. A first-word-fall-through transmit FIFO presents outgoing packets to the arbiter, and a receive FIFO captures packets the arbiter pushes. Host logic writes and reads through simple valid/ready-free strobes and gets sticky overflow status.

## Interface
- `bits`, 32, packet width; destination ID is `D[bits-1 -: id_bits]`
- `id_bits`, 8, destination-field width
- `drvr_id`, 0, this endpoint's ID (`id_bits` wide)
- `broadcast`, `{8{1'b1}}`, broadcast destination value
- `depth`, 16, entries per FIFO, power of two, ≥2
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `tx_wr` in 1: host write strobe
- `tx_data` in `bits`: host packet to send
- `tx_full` out 1: TX FIFO holds `depth` entries
- `pndng` out 1: TX FIFO non-empty (to arbiter)
- `pop` in 1: arbiter consumes TX head
- `D_pop` out `bits`: TX head, valid while `pndng`
- `push` in 1: arbiter delivers a packet
- `D_push` in `bits`: delivered packet
- `rx_rd` in 1: host read strobe
- `rx_data` out `bits`: RX head, valid while `!rx_empty`
- `rx_empty` out 1: RX FIFO empty
- `rx_count` out `$clog2(depth+1)`: RX occupancy
- `sts_clr` in 1: synchronous clear of sticky status and counter
- `tx_ovf` out 1: sticky, a write was dropped
- `rx_ovf` out 1: sticky, a push was dropped because RX was full
- `rx_misroute` out 8: saturating count of pushes with a foreign destination

## Operation
- TX FIFO:
  - `tx_wr` with `!tx_full` stores `tx_data`.
  - `tx_wr` with `tx_full` and `pop` in the same cycle is also stored; occupancy is unchanged.
  - `tx_wr` with `tx_full` and no `pop` is dropped and sets `tx_ovf`.
- `pndng` = TX occupancy ≠ 0.
- `D_pop` = TX head when `pndng`, otherwise all zeros.
- `pop` with `!pndng` is ignored; no pointer moves and no error is flagged.
- RX accept rule: `push` is accepted when the destination field equals `drvr_id` or `broadcast`.
  - Any other destination is discarded and increments `rx_misroute`, which saturates at 255.
- Accepted push with RX full:
  - If `rx_rd` is asserted in the same cycle, the push is stored.
  - Otherwise it is dropped and sets `rx_ovf`.
- `rx_data` = RX head when `!rx_empty`, otherwise zeros.
- `rx_rd` while empty is ignored.
- `sts_clr` clears `tx_ovf`, `rx_ovf` and `rx_misroute`. If an error occurs in the same cycle as `sts_clr`, the error wins (flag set / count = 1).
- Pointers are `$clog2(depth)` bits and wrap naturally. Occupancy counters are `$clog2(depth+1)` bits.

## Timing
- Reset (asynchronous assert, synchronous release to first edge):
  - pointers, counts and status = 0
  - `pndng`=0, `tx_full`=0, `D_pop`=0, `rx_empty`=1, `rx_data`=0
- Reset mid-operation discards all FIFO contents immediately.
- TX write to `pndng`: a write at edge N makes `pndng`=1 and `D_pop` valid after edge N (1-cycle latency).
- `pop` at edge N: `D_pop` shows the next entry after edge N, and `pndng` falls if that was the last entry.
- Back-to-back `pop` every cycle is supported, giving a throughput of 1 packet/cycle.
- Simultaneous write and pop on an empty TX FIFO: `pop` is ignored and the write is stored, so `pndng`=1 next cycle.
- RX push at edge N is visible on `rx_data`/`rx_count` after edge N.
- All outputs are registered or decoded only from registered state. There is no combinational path from `pop`/`push` to any output.

## Structure
- Package `prll_bs_pkg` holds:
  - `id_bits` default and the broadcast constant
  - function `dest_of(pkt)` returning the destination field
- Sub-module `prll_bs_sync_fifo` (`bits`, `depth`): FWFT, `wr`/`rd`/`din`/`dout`/`count`/`full`/`empty`, write-when-full-with-read allowed. It is instantiated twice (TX and RX).
- The top holds the accept filter, drop/overflow logic and status registers.

## Test plan
- Reset, then write 3 packets `0x00000011`, `0x00000022`, `0x00000033`:
  - `pndng`=1 one cycle after the first write, `D_pop`=`0x00000011`.
  - 3 consecutive `pop`s yield `0x11`, `0x22`, `0x33`, then `pndng`=0 and `D_pop`=0.
- Fill TX with 16 writes:
  - A 17th `tx_wr` with no `pop` is dropped, `tx_ovf`=1, and the contents are intact.
  - A 17th write with a coincident `pop` is stored, `tx_full` stays 1, and `tx_ovf` is unchanged.
- With `drvr_id`=3:
  - push `0x03ABCDEF` is accepted and push `0xFF000001` is accepted.
  - push `0x05000000` is rejected and `rx_misroute`=1.
  - `rx_count`=2 and reads return them in order.
- Fill RX with 16 accepted pushes:
  - A 17th push with no `rx_rd` is dropped and `rx_ovf`=1.
  - `sts_clr` clears it. `sts_clr` coincident with another drop leaves `rx_ovf`=1.
- Assert `reset` mid-stream with 5 TX and 4 RX entries:
  - Outputs return to their reset values in the same cycle.
  - After release, `pop`/`rx_rd` are ignored until new data arrives.
- Wrap-around: 40 interleaved write/pop cycles with random gaps; TX order matches a scoreboard across pointer wrap.
